// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding, default widths and
// the request record a port presents.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RD     = 2'd2,
    ST_RD_CAP = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational picker: a lone eligible port wins; on a tie either
// port 0 (fixed priority) or the port not granted last time wins.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last,
  input  logic       prio_p0,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |eligible;
    grant_idx   = 1'b0;
    case (eligible)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = prio_p0 ? 1'b0 : ~last;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a synchronous RAM: one access at a time,
// single-cycle enable pulses, registered outputs and a one-cycle ack per port.
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int P0_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              ack_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              ack_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic [1:0]        eligible;
  logic              prio_p0;
  logic              grant_valid;
  logic              grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port whose ack is on this cycle is masked so it cannot be granted twice.
  assign eligible = {req_1 & ~ack_q[1], req_0 & ~ack_q[0]};
  assign prio_p0  = (P0_PRIORITY != 0);

  rr_arb2 u_pick (
    .eligible    (eligible),
    .last        (last_q),
    .prio_p0     (prio_p0),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? we_1    : we_0;
  assign sel_addr  = grant_idx ? addr_1  : addr_0;
  assign sel_wdata = grant_idx ? wdata_1 : wdata_0;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_wdata_d = '0;
    ack_d       = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          winner_d   = grant_idx;
          last_d     = grant_idx;
          mem_addr_d = sel_addr;
          if (sel_we) begin
            state_d     = ST_WR;
            mem_wen_d   = 1'b1;
            mem_wdata_d = sel_wdata;
          end else begin
            state_d   = ST_RD;
            mem_ren_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        ack_d   = winner_q ? 2'b10 : 2'b01;
      end
      ST_RD: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        // The RAM registered its data at the end of RD; it is stable on the bus now.
        state_d = ST_IDLE;
        ack_d   = winner_q ? 2'b10 : 2'b01;
        if (winner_q) rdata1_d = mem_rdata;
        else          rdata0_d = mem_rdata;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      winner_q    <= 1'b0;
      last_q      <= 1'b1;
      mem_addr_q  <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      ack_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  assign ack_0     = ack_q[0];
  assign ack_1     = ack_q[1];
  assign rdata_0   = rdata0_q;
  assign rdata_1   = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_drive = mem_wen_q;
  assign busy      = busy_q;

endmodule
